// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a 6-input MUX: picks a requester, steers the MUX select,
// captures the settled MUX output and hands it downstream on valid/ready with a grant pulse.
module mux_rr_scheduler #(
    parameter int NUM_REQ = 6,
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   M_select,
    input  logic [DATA_W-1:0]  M_out,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

    localparam logic [SEL_W:0] NREQ = (SEL_W+1)'(NUM_REQ);
    localparam logic [SEL_W:0] ONE  = (SEL_W+1)'(1);

    state_t             state;
    logic [SEL_W-1:0]   last;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;
    logic [SEL_W:0]     sum;
    logic [SEL_W-1:0]   winner;
    logic               any_req;

    // Rotate the doubled request vector so bit 0 is the slot right after 'last',
    // then the lowest set bit is the round-robin winner's offset.
    always_comb begin
        masked  = req & ~gnt;
        any_req = |masked;
        rot     = NUM_REQ'({masked, masked} >> ({1'b0, last} + ONE));
        off     = '0;
        for (int j = NUM_REQ-1; j >= 0; j--) begin
            if (rot[j]) off = SEL_W'(j);
        end
        sum    = {1'b0, last} + {1'b0, off} + ONE;
        winner = (sum >= NREQ) ? SEL_W'(sum - NREQ) : SEL_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            M_select  <= '0;
            gnt       <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            last      <= SEL_W'(NUM_REQ-1);
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        M_select <= winner;
                        state    <= SAMPLE;
                    end
                end
                // M_select has been stable a full cycle, so M_out has settled.
                SAMPLE: begin
                    out_data  <= M_out;
                    out_src   <= M_select;
                    out_valid <= 1'b1;
                    gnt       <= NUM_REQ'(1) << M_select;
                    last      <= M_select;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (any_req) begin
                            M_select <= winner;
                            state    <= SAMPLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: stimulus pushes expected words, a negedge monitor
// pops and compares on every accepted transfer and checks grant pulses.
module tb_mux_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] req;
    logic [5:0] gnt;
    logic [2:0] M_select;
    logic [3:0] M_out;
    logic [3:0] out_data;
    logic [2:0] out_src;
    logic       out_valid;
    logic       out_ready;

    logic [3:0] a [8];
    logic [6:0] sb [$];
    int         xfer_cyc [$];
    int         tests = 0;
    int         fails = 0;
    int         xfer_cnt = 0;
    int         gnt_cnt = 0;
    int         cyc = 0;
    logic       gnt_prev = 1'b0;

    mux_rr_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .M_select(M_select),
        .M_out(M_out), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    assign M_out = a[M_select];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 6'd0) begin
                gnt_cnt++;
                tests++;
                if (!(out_valid && gnt == (6'd1 << out_src) && !gnt_prev)) begin
                    fails++;
                    $display("FAIL gnt_pulse: gnt=%b out_src=%0d out_valid=%b prev=%b", gnt, out_src, out_valid, gnt_prev);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got src=%0d data=%h, none expected", out_src, out_data);
                end else begin
                    logic [6:0] e;
                    e = sb.pop_front();
                    if ({out_src, out_data} != e) begin
                        fails++;
                        $display("FAIL word: got src=%0d data=%h, expected src=%0d data=%h", out_src, out_data, e[6:4], e[3:0]);
                    end
                end
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
            end
            gnt_prev = (gnt != 6'd0);
        end else begin
            gnt_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_xfers(input string name, input int target);
        int n = 0;
        while (xfer_cnt < target && n < 60) begin tick(); n++; end
        if (xfer_cnt < target) check({name, "_timeout"}, xfer_cnt, target);
    endtask

    // Advance to the HOLD cycle of the word that will bring xfer_cnt to target.
    task automatic wait_last_hold(input string name, input int target);
        int n = 0;
        while (!(out_valid && xfer_cnt == target - 1) && n < 60) begin tick(); n++; end
        if (!(out_valid && xfer_cnt == target - 1)) check({name, "_timeout"}, xfer_cnt, target - 1);
    endtask

    initial begin
        int base, g0, x0;
        a[0] = 4'h1; a[1] = 4'h2; a[2] = 4'h4; a[3] = 4'hA;
        a[4] = 4'h8; a[5] = 4'hF; a[6] = 4'h0; a[7] = 4'h0;
        reset = 1'b1; req = 6'h3F; out_ready = 1'b1;

        // 1: reset with all requests asserted
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_gnt", gnt, 0);
        check("rst_M_select", M_select, 0);

        // 3: all requesters held, full rotation starting from index 0
        for (int i = 0; i < 7; i++) sb.push_back({3'(i % 6), a[i % 6]});
        base = xfer_cnt;
        reset = 1'b0;
        wait_last_hold("rot", base + 7);
        req = 6'h00;
        wait_xfers("rot", base + 7);
        if (xfer_cyc.size() >= base + 7)
            check("rot_span_cycles", xfer_cyc[base + 6] - xfer_cyc[base], 12);
        tick(); tick();
        check("rot_idle", out_valid, 0);

        // 2: single requester 3, latency
        req = 6'b001000;
        sb.push_back({3'd3, 4'hA});
        tick();
        check("lat_M_select", M_select, 3);
        check("lat_no_valid", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 4'hA);
        check("lat_src", out_src, 3);
        check("lat_gnt", gnt, 6'b001000);
        req = 6'h00;
        tick();
        check("lat_done", out_valid, 0);

        // 4: backpressure on requester 1
        out_ready = 1'b0;
        req = 6'b000010;
        sb.push_back({3'd1, a[1]});
        g0 = gnt_cnt;
        wait_valid("bp");
        req = 6'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable", {out_valid, out_src, out_data}, {1'b1, 3'd1, a[1]});
        end
        check("bp_gnt_once", gnt_cnt - g0, 1);
        x0 = xfer_cnt;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick(); tick();
        check("bp_single_xfer", xfer_cnt - x0, 1);
        check("bp_valid_low", out_valid, 0);

        // 5: lone requester 2 held high keeps being served
        out_ready = 1'b1;
        req = 6'b000100;
        g0 = gnt_cnt;
        base = xfer_cnt;
        for (int i = 0; i < 4; i++) sb.push_back({3'd2, a[2]});
        wait_last_hold("solo", base + 4);
        req = 6'h00;
        wait_xfers("solo", base + 4);
        if (xfer_cyc.size() >= base + 4)
            for (int k = 1; k < 4; k++)
                check("solo_gap_le3", int'(xfer_cyc[base + k] - xfer_cyc[base + k - 1] <= 3), 1);
        check("solo_gnts", gnt_cnt - g0, 4);
        tick(); tick();

        // 6: reset while a word is held
        out_ready = 1'b0;
        req = 6'b010000;
        wait_valid("rsthold");
        x0 = xfer_cnt;
        reset = 1'b1;
        req = 6'h00;
        tick();
        check("rsthold_valid", out_valid, 0);
        check("rsthold_gnt", gnt, 0);
        check("rsthold_M_select", M_select, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("rsthold_dropped", xfer_cnt - x0, 0);
        check("rsthold_idle", out_valid, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
